// File: rtl/em_pipe_reg.sv
// ============================================================================
//  Module   : em_pipe_reg
//  Brief    : E/M pipeline register of the 5-stage MIPS pipeline, with stall,
//             flush, Tnew countdown and $0-write suppression.
//             Optional bubble/stall counters when EM_PERF_CNT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module em_pipe_reg #(
  parameter int          WIDTH     = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             flush,
  input  logic [31:0]      INSTR_E,
  input  logic [WIDTH-1:0] PC_E,
  input  logic [WIDTH-1:0] ALUout_E,
  input  logic [WIDTH-1:0] RTdata_E,
  input  logic [4:0]       A3_E,
  input  logic             RFWr_E,
  input  logic [2:0]       Tnew_E,
  output logic [31:0]      INSTR_M,
  output logic [WIDTH-1:0] PC_M,
  output logic [WIDTH-1:0] ALUout_M,
  output logic [WIDTH-1:0] RTdata_M,
  output logic [4:0]       A3_M,
  output logic             RFWr_Mq,
  output logic [2:0]       Tnew_Mq,
`ifdef EM_PERF_CNT_EN
  output logic [31:0]      bubble_cnt,
  output logic [31:0]      stall_cnt,
`endif
  output logic             valid_M
);

  localparam logic [2:0] c_TNEW_NEVER = 3'b111;

  logic [31:0]      r_instr;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_alu;
  logic [WIDTH-1:0] r_rtdata;
  logic [4:0]       r_a3;
  logic             r_rfwr;
  logic [2:0]       r_tnew;
  logic             r_valid;

  logic             w_wr_ok;
  logic [2:0]       w_tnew_dec;

  // A write to $0 is dropped here so downstream hazard compares never match it.
  assign w_wr_ok = RFWr_E && (A3_E != 5'd0);

  always_comb begin
    w_tnew_dec = Tnew_E;
    if (Tnew_E != c_TNEW_NEVER && Tnew_E != 3'd0)
      w_tnew_dec = Tnew_E - 3'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset || flush) begin
      r_instr  <= NOP_INSTR;
      r_pc     <= '0;
      r_alu    <= '0;
      r_rtdata <= '0;
      r_a3     <= 5'd0;
      r_rfwr   <= 1'b0;
      r_tnew   <= 3'd0;
      r_valid  <= 1'b0;
    end else if (en) begin
      r_instr  <= INSTR_E;
      r_pc     <= PC_E;
      r_alu    <= ALUout_E;
      r_rtdata <= RTdata_E;
      r_a3     <= w_wr_ok ? A3_E : 5'd0;
      r_rfwr   <= w_wr_ok;
      r_tnew   <= w_tnew_dec;
      r_valid  <= 1'b1;
    end
  end

  assign INSTR_M  = r_instr;
  assign PC_M     = r_pc;
  assign ALUout_M = r_alu;
  assign RTdata_M = r_rtdata;
  assign A3_M     = r_a3;
  assign RFWr_Mq  = r_rfwr;
  assign Tnew_Mq  = r_tnew;
  assign valid_M  = r_valid;

`ifdef EM_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_cnt <= 32'd0;
      r_stall_cnt  <= 32'd0;
    end else if (flush) begin
      r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end else if (!en) begin
      r_stall_cnt  <= r_stall_cnt + 32'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign stall_cnt  = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_em_pipe_reg.sv
// ============================================================================
//  Module   : tb_em_pipe_reg
//  Brief    : Directed self-checking bench for em_pipe_reg (counters checked
//             when EM_PERF_CNT_EN is defined).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_em_pipe_reg;

  logic        clk;
  logic        reset;
  logic        en;
  logic        flush;
  logic [31:0] INSTR_E;
  logic [31:0] PC_E;
  logic [31:0] ALUout_E;
  logic [31:0] RTdata_E;
  logic [4:0]  A3_E;
  logic        RFWr_E;
  logic [2:0]  Tnew_E;
  logic [31:0] INSTR_M;
  logic [31:0] PC_M;
  logic [31:0] ALUout_M;
  logic [31:0] RTdata_M;
  logic [4:0]  A3_M;
  logic        RFWr_Mq;
  logic [2:0]  Tnew_Mq;
  logic        valid_M;
`ifdef EM_PERF_CNT_EN
  logic [31:0] bubble_cnt;
  logic [31:0] stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  em_pipe_reg #(
    .WIDTH     (32),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .flush    (flush),
    .INSTR_E  (INSTR_E),
    .PC_E     (PC_E),
    .ALUout_E (ALUout_E),
    .RTdata_E (RTdata_E),
    .A3_E     (A3_E),
    .RFWr_E   (RFWr_E),
    .Tnew_E   (Tnew_E),
    .INSTR_M  (INSTR_M),
    .PC_M     (PC_M),
    .ALUout_M (ALUout_M),
    .RTdata_M (RTdata_M),
    .A3_M     (A3_M),
    .RFWr_Mq  (RFWr_Mq),
    .Tnew_Mq  (Tnew_Mq),
`ifdef EM_PERF_CNT_EN
    .bubble_cnt (bubble_cnt),
    .stall_cnt  (stall_cnt),
`endif
    .valid_M  (valid_M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [31:0] e_instr, input logic [31:0] e_pc,
                         input logic [31:0] e_alu,   input logic [31:0] e_rt,
                         input logic [4:0]  e_a3,    input logic e_rfwr,
                         input logic [2:0]  e_tnew,  input logic e_valid);
    chk({tag, ".INSTR_M"},  INSTR_M,  e_instr);
    chk({tag, ".PC_M"},     PC_M,     e_pc);
    chk({tag, ".ALUout_M"}, ALUout_M, e_alu);
    chk({tag, ".RTdata_M"}, RTdata_M, e_rt);
    chk({tag, ".A3_M"},     {27'd0, A3_M},    {27'd0, e_a3});
    chk({tag, ".RFWr_Mq"},  {31'd0, RFWr_Mq}, {31'd0, e_rfwr});
    chk({tag, ".Tnew_Mq"},  {29'd0, Tnew_Mq}, {29'd0, e_tnew});
    chk({tag, ".valid_M"},  {31'd0, valid_M}, {31'd0, e_valid});
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] alu,   input logic [31:0] rt,
                       input logic [4:0]  a3,    input logic rfwr,
                       input logic [2:0]  tnew);
    INSTR_E  = instr;
    PC_E     = pc;
    ALUout_E = alu;
    RTdata_E = rt;
    A3_E     = a3;
    RFWr_E   = rfwr;
    Tnew_E   = tnew;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    flush = 1'b0;
    drive(32'h1234_5678, 32'h0000_0ABC, 32'h1111_1111, 32'h2222_2222, 5'd9, 1'b1, 3'd2);

    // Reset held across edges with en=1: nothing may load.
    step();
    step();
    chk_all("reset", 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0);
`ifdef EM_PERF_CNT_EN
    chk("reset.bubble_cnt", bubble_cnt, 32'd0);
    chk("reset.stall_cnt",  stall_cnt,  32'd0);
`endif

    // add $3,$1,$2
    @(negedge clk);
    reset = 1'b0;
    drive(32'h0022_1820, 32'h0000_3000, 32'd5, 32'd2, 5'd3, 1'b1, 3'd1);
    step();
    chk_all("add", 32'h0022_1820, 32'h3000, 32'd5, 32'd2, 5'd3, 1'b1, 3'd0, 1'b1);

    // lw $2,4($1) with Tnew=2, then three stall cycles with changing inputs
    @(negedge clk);
    drive(32'h8C22_0004, 32'h0000_3004, 32'h0000_0010, 32'h0000_0077, 5'd2, 1'b1, 3'd2);
    step();
    chk_all("lw", 32'h8C22_0004, 32'h3004, 32'h10, 32'h77, 5'd2, 1'b1, 3'd1, 1'b1);

    @(negedge clk);
    en = 1'b0;
    drive(32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555, 32'hCCCC_CCCC, 5'd17, 1'b1, 3'd3);
    step();
    chk_all("stall1", 32'h8C22_0004, 32'h3004, 32'h10, 32'h77, 5'd2, 1'b1, 3'd1, 1'b1);
    step();
    step();
    chk_all("stall3", 32'h8C22_0004, 32'h3004, 32'h10, 32'h77, 5'd2, 1'b1, 3'd1, 1'b1);
`ifdef EM_PERF_CNT_EN
    chk("stall.stall_cnt",  stall_cnt,  32'd3);
    chk("stall.bubble_cnt", bubble_cnt, 32'd0);
`endif

    // flush together with en=0 beats the stall
    @(negedge clk);
    flush = 1'b1;
    step();
    chk_all("flush", 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0);
`ifdef EM_PERF_CNT_EN
    chk("flush.bubble_cnt", bubble_cnt, 32'd1);
    chk("flush.stall_cnt",  stall_cnt,  32'd3);
`endif

    // ori $0,$1,7: write to $0 suppressed, data still carried
    @(negedge clk);
    flush = 1'b0;
    en    = 1'b1;
    drive(32'h3420_0007, 32'h0000_3008, 32'd7, 32'h0, 5'd0, 1'b1, 3'd1);
    step();
    chk_all("ori0", 32'h3420_0007, 32'h3008, 32'd7, 32'h0, 5'd0, 1'b0, 3'd0, 1'b1);

    // sw: never produces, no write even though A3_E is nonzero
    @(negedge clk);
    drive(32'hAC22_0000, 32'h0000_300C, 32'h0000_0020, 32'hDEAD_BEEF, 5'd2, 1'b0, 3'b111);
    step();
    chk_all("sw", 32'hAC22_0000, 32'h300C, 32'h20, 32'hDEAD_BEEF, 5'd0, 1'b0, 3'b111, 1'b1);

    // upstream NOP with Tnew=3 still counts as a valid load
    @(negedge clk);
    drive(32'h0000_0000, 32'h0000_3010, 32'hFFFF_FFFF, 32'h8000_0001, 5'd8, 1'b1, 3'd3);
    step();
    chk_all("nop", 32'h0, 32'h3010, 32'hFFFF_FFFF, 32'h8000_0001, 5'd8, 1'b1, 3'd2, 1'b1);

    // jal: Tnew_E=0 stays 0; then asynchronous reset between edges
    @(negedge clk);
    drive(32'h0C00_0C10, 32'h0000_3014, 32'h0000_301C, 32'h0, 5'd31, 1'b1, 3'd0);
    step();
    chk_all("jal", 32'h0C00_0C10, 32'h3014, 32'h301C, 32'h0, 5'd31, 1'b1, 3'd0, 1'b1);

    #2;
    reset = 1'b1;
    #1;
    chk_all("async_rst", 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 3'd0, 1'b0);
`ifdef EM_PERF_CNT_EN
    chk("async_rst.bubble_cnt", bubble_cnt, 32'd0);
    chk("async_rst.stall_cnt",  stall_cnt,  32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
